// File: rtl/seq_multu.sv
// rtl/seq_multu.sv - multi-cycle unsigned shift-add multiplier feeding the HI/LO writer interface
module seq_multu #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  MULTU = 6'd1,
    parameter logic [5:0]  MADDU = 6'd28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [5:0]           op_in,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   mul_ans,
    output logic [5:0]           op_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [5:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   mul_ans_q, mul_ans_d;
    logic [5:0]           op_out_q, op_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH:0]       t;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        p_d       = p_q;
        op_d      = op_q;
        mul_ans_d = mul_ans_q;
        op_out_d  = op_out_q;
        done_d    = 1'b0;
        // Upper half plus the conditional multiplicand, carry kept so it lands in the top bit.
        t = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});

        case (state_q)
            IDLE: begin
                if (start && (op_in == MULTU || op_in == MADDU)) begin
                    m_d     = a;
                    p_d     = {{WIDTH{1'b0}}, b};
                    op_d    = op_in;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                p_d   = {t, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                mul_ans_d = p_q;
                op_out_d  = op_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            m_q       <= '0;
            p_q       <= '0;
            op_q      <= '0;
            mul_ans_q <= '0;
            op_out_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            p_q       <= p_d;
            op_q      <= op_d;
            mul_ans_q <= mul_ans_d;
            op_out_q  <= op_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign mul_ans = mul_ans_q;
    assign op_out  = op_out_q;

endmodule

// File: tb/tb_seq_multu.sv
// tb/tb_seq_multu.sv - directed and randomized checks of seq_multu against an arithmetic reference
module tb_seq_multu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  op_in;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] mul_ans;
    logic [5:0]  op_out;

    int checks = 0;
    int errors = 0;

    seq_multu dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_in   (op_in),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .mul_ans (mul_ans),
        .op_out  (op_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xx;
        logic [63:0] yy;
        xx = {32'd0, x};
        yy = {32'd0, y};
        return xx * yy;
    endfunction

    task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic [5:0] op);
        start = 1'b1;
        a     = av;
        b     = bv;
        op_in = op;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called right after launch: lat counts negedges from the accepting edge to the done cycle.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = busy ? 1 : 0;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic watch_no_done(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
    endtask

    initial begin
        int          lat;
        int          bcnt;
        int          seen;
        logic [63:0] last;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [5:0]  rop;

        rst = 1'b1; start = 1'b0; op_in = 6'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_ans", mul_ans, 64'd0);
        chk("reset_op", {58'd0, op_out}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 3*5, latency and busy length
        launch(32'd3, 32'd5, 6'd1);
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
        wait_done(lat, bcnt);
        chk("lat_3x5", 64'(lat), 64'd34);
        chk("busy_cycles_3x5", 64'(bcnt), 64'd33);
        chk("ans_3x5", mul_ans, 64'd15);
        chk("op_3x5", {58'd0, op_out}, 64'd1);
        @(negedge clk);
        chk("done_pulse_width", {63'd0, done}, 64'd0);
        repeat (3) @(negedge clk);
        chk("ans_stable", mul_ans, 64'd15);
        chk("op_stable", {58'd0, op_out}, 64'd1);

        // all-ones: carry into top bit
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd28);
        wait_done(lat, bcnt);
        chk("ans_max", mul_ans, 64'hFFFF_FFFE_0000_0001);
        chk("op_max", {58'd0, op_out}, 64'd28);

        // zero multiplicand keeps fixed latency
        launch(32'd0, 32'h1234_5678, 6'd1);
        wait_done(lat, bcnt);
        chk("lat_zero", 64'(lat), 64'd34);
        chk("ans_zero", mul_ans, 64'd0);
        last = mul_ans;

        // illegal opcode ignored
        @(negedge clk);
        launch(32'd9, 32'd9, 6'd5);
        chk("badop_busy", {63'd0, busy}, 64'd0);
        watch_no_done(40, seen);
        chk("badop_no_done", 64'(seen), 64'd0);
        chk("badop_ans_kept", mul_ans, last);

        // start during CALC ignored, operand changes have no effect
        launch(32'd7, 32'd9, 6'd1);
        repeat (8) @(negedge clk);
        launch(32'd2, 32'd2, 6'd28);
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        wait_done(lat, bcnt);
        chk("ans_ignore_mid", mul_ans, 64'd63);
        chk("op_ignore_mid", {58'd0, op_out}, 64'd1);
        repeat (2) @(negedge clk);
        chk("not_queued_busy", {63'd0, busy}, 64'd0);

        // reset mid-CALC aborts
        launch(32'd100, 32'd100, 6'd1);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_ans", mul_ans, 64'd0);
        chk("abort_op", {58'd0, op_out}, 64'd0);
        watch_no_done(40, seen);
        chk("abort_no_done", 64'(seen), 64'd0);
        launch(32'd6, 32'd7, 6'd1);
        wait_done(lat, bcnt);
        chk("ans_after_abort", mul_ans, 64'd42);

        // reset and start together: reset wins
        @(negedge clk);
        rst = 1'b1;
        launch(32'd11, 32'd11, 6'd1);
        rst = 1'b0;
        chk("rst_start_busy", {63'd0, busy}, 64'd0);
        watch_no_done(40, seen);
        chk("rst_start_no_done", 64'(seen), 64'd0);

        // back-to-back: start in the done cycle is accepted
        launch(32'd12, 32'd13, 6'd28);
        wait_done(lat, bcnt);
        chk("b2b_first", mul_ans, 64'd156);
        launch(32'd21, 32'd2, 6'd1);
        chk("b2b_accept_busy", {63'd0, busy}, 64'd1);
        chk("b2b_ans_held", mul_ans, 64'd156);
        wait_done(lat, bcnt);
        chk("b2b_lat", 64'(lat), 64'd34);
        chk("b2b_second", mul_ans, 64'd42);

        // randomized operands against the arithmetic reference
        for (int i = 0; i < 8; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = ($urandom_range(0, 1) == 0) ? 6'd1 : 6'd28;
            @(negedge clk);
            launch(ra, rb, rop);
            wait_done(lat, bcnt);
            chk("rand_ans", mul_ans, ref_mul(ra, rb));
            chk("rand_op", {58'd0, op_out}, {58'd0, rop});
            chk("rand_lat", 64'(lat), 64'd34);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multu.md
Name: seq_multu

Overview:
- Multi-cycle unsigned 32x32 shift-add multiplier.
- Produces the 64-bit product and the operation code consumed by the HI/LO accumulator register.
- Acts as the writer side of the HI/LO interface: it tells HI/LO when to overwrite (MULTU) and when to accumulate (MADDU).
- Sits in the execute stage beside the ALU. The controller starts it and stalls on busy.

Parameters:
- WIDTH, 32, operand width. Product width is 2*WIDTH.
- MULTU, 6'd1, opcode meaning "overwrite HI/LO with product".
- MADDU, 6'd28, opcode meaning "add product to HI/LO".

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- op_in  input  6  opcode accompanying start; must be MULTU or MADDU.
- a  input  WIDTH  multiplicand, latched on accept.
- b  input  WIDTH  multiplier, latched on accept.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; product and opcode valid.
- mul_ans  output  2*WIDTH  product; held stable from done until the next accept.
- op_out  output  6  latched opcode; held stable like mul_ans; 6'd0 when no valid result.

Behaviour:
- Reset (rst high at a clk edge, checked first and overriding everything):
  - state=IDLE, counter=0.
  - mul_ans=0, op_out=0, busy=0, done=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start=1 and op_in is MULTU or MADDU, then:
    - latch M=a;
    - P={WIDTH'b0, b};
    - latch op;
    - counter=0;
    - go to CALC.
  - If start=1 with any other op_in, ignore the request and stay in IDLE. No flag is raised.
  - mul_ans and op_out keep their previous values.
- CALC, one iteration per edge:
  - Compute t = P[63:32] + (P[0] ? M : 0) as WIDTH+1 bits, keeping the carry.
  - Then P = {t, P[31:1]}, a logical right shift with the carry shifted into bit 63.
  - counter increments each iteration.
  - After the iteration where counter reaches WIDTH-1, go to DONE. That is WIDTH edges in CALC.
- DONE (exactly one cycle):
  - mul_ans=P, op_out=latched op, done=1.
  - On the next edge, return to IDLE.
- Outputs are registered. done is high only during the DONE cycle.
- Latency: start sampled at edge E0 → done high in the cycle after edge E(WIDTH+1). That is WIDTH+1 edges, fixed, with no early termination for zero operands.
- Requests arriving outside IDLE:
  - start while in CALC or DONE is ignored, not queued.
  - Operand changes during CALC have no effect.
- The product is exact unsigned with no overflow; the 64-bit result fits by construction.
- Reset mid-CALC or mid-DONE aborts the operation:
  - no done pulse is issued;
  - mul_ans and op_out are zeroed.
- Simultaneous rst and start: reset wins and start is dropped.
- A start in the cycle right after DONE (state now IDLE) is accepted normally. The back-to-back throughput is one result per WIDTH+2 cycles.

Test Plan:
- Reset, then start with a=3, b=5, op=1 → busy high for 33 cycles; done pulses once; mul_ans=64'd15, op_out=6'd1; values remain stable afterwards.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF, op=28 → mul_ans=64'hFFFFFFFE_00000001, op_out=6'd28; confirms carry into bit 63.
- a=0, b=32'h12345678 → mul_ans=0; done appears at the same latency as the non-zero case.
- Start op=6'd5 in IDLE → stays IDLE; busy=0; done never asserts; mul_ans unchanged from the previous result.
- Start a=7, b=9 op=1, then at cycle 10 assert start with a=2, b=2 → second request ignored; mul_ans=64'd63.
- Start a=100, b=100; assert rst at cycle 15 for one cycle → busy=0 and mul_ans=0 next cycle; no done pulse. A new start with a=6, b=7 then gives 64'd42.
